// File: rtl/key_add_pipe.sv
// Round-key XOR stage: key store of NUM_KEYS slots plus one valid/ready output register.
// Optional macro KEY_ADD_ZEROIZE_EN adds a zeroize input that wipes the key store and drops the held beat.
module key_add_pipe #(
    parameter int DATA_W   = 128,
    parameter int NUM_KEYS = 11
) (
    input  logic                clk,
    input  logic                n_rst,
`ifdef KEY_ADD_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic                key_wr_en,
    input  logic [3:0]          key_wr_idx,
    input  logic [DATA_W-1:0]   key_wr_data,
    output logic [NUM_KEYS-1:0] key_loaded,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [3:0]          in_round,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_err
);

    logic [DATA_W-1:0]   key_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_loaded_q;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_err_q, out_err_d;
    logic [DATA_W-1:0]   key_sel_s;
    logic                key_hit_s;
    logic                accept_s;
    logic                zeroize_s;

`ifdef KEY_ADD_ZEROIZE_EN
    assign zeroize_s = zeroize;
`else
    assign zeroize_s = 1'b0;
`endif

    assign in_ready   = !zeroize_s && (!out_valid_q || out_ready);
    assign accept_s   = in_valid && in_ready;
    assign key_loaded = key_loaded_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;

    // Key lookup: out-of-range rounds match no slot and therefore read as unloaded.
    always_comb begin
        key_sel_s = '0;
        key_hit_s = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_sel_s = key_sel_s | (key_q[i] & {DATA_W{in_round == 4'(i)}});
            key_hit_s = key_hit_s | (key_loaded_q[i] & (in_round == 4'(i)));
        end
    end

    // Output stage next state: zeroize drops the beat, accept loads, drain clears valid.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        if (zeroize_s) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_err_d   = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = key_hit_s ? (in_data ^ key_sel_s) : in_data;
            out_err_d   = !key_hit_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    // Key store; the lookup above reads the pre-write value, so a same-cycle beat sees the old key.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_loaded_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_q[i] <= '0;
            end
        end else if (zeroize_s) begin
            key_loaded_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_wr_en && (key_wr_idx == 4'(i))) begin
                    key_q[i]        <= key_wr_data;
                    key_loaded_q[i] <= 1'b1;
                end else begin
                    key_q[i]        <= key_q[i];
                    key_loaded_q[i] <= key_loaded_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_key_add_pipe.sv
// Scoreboard bench for key_add_pipe: driver pushes expected beats from a key-store model, monitor pops on transfer.
module tb_key_add_pipe;

    localparam int NK = 11;

    typedef struct packed {
        logic [127:0] data;
        logic         err;
    } beat_t;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          zeroize = 1'b0;
    logic          key_wr_en = 1'b0;
    logic [3:0]    key_wr_idx = 4'd0;
    logic [127:0]  key_wr_data = 128'd0;
    logic [NK-1:0] key_loaded;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  in_data = 128'd0;
    logic [3:0]    in_round = 4'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [127:0]  out_data;
    logic          out_err;

    int checks = 0;
    int errors = 0;
    beat_t sb[$];
    logic [127:0]  mkey [NK];
    logic [NK-1:0] mload;

    key_add_pipe #(.DATA_W(128), .NUM_KEYS(NK)) dut (
        .clk(clk), .n_rst(n_rst),
`ifdef KEY_ADD_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .key_loaded(key_loaded), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_round(in_round), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic beat_t model_beat(input logic [3:0] r, input logic [127:0] d);
        beat_t b;
        int ri;
        ri = int'(r);
        b.data = d;
        b.err  = 1'b1;
        if (ri < NK) begin
            if (mload[ri]) begin
                b.data = d ^ mkey[ri];
                b.err  = 1'b0;
            end
        end
        return b;
    endfunction

    task automatic clear_model();
        sb.delete();
        mload = '0;
        for (int i = 0; i < NK; i++) mkey[i] = 128'd0;
    endtask

    // One clock of stimulus; expected beat is pushed once the handshake outcome is known.
    task automatic cycle(input logic v, input logic [3:0] r, input logic [127:0] d, input logic ordy,
                         input logic kw, input logic [3:0] ki, input logic [127:0] kd,
                         input logic z, output logic acc);
        @(posedge clk); #1;
        in_valid = v; in_round = r; in_data = d; out_ready = ordy;
        key_wr_en = kw; key_wr_idx = ki; key_wr_data = kd; zeroize = z;
        @(negedge clk); #1;
        acc = v && in_ready;
        if (z) begin
            clear_model();
        end else begin
            if (acc) sb.push_back(model_beat(r, d));
            if (kw && int'(ki) < NK) begin
                mkey[int'(ki)]  = kd;
                mload[int'(ki)] = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic ordy);
        logic a;
        cycle(1'b0, 4'd0, 128'd0, ordy, 1'b0, 4'd0, 128'd0, 1'b0, a);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        in_valid = 1'b0; key_wr_en = 1'b0; out_ready = 1'b0; zeroize = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_err", {127'd0, out_err}, 128'd0);
        chk("rst_key_loaded", {117'd0, key_loaded}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        clear_model();
        @(negedge clk); #1;
        n_rst = 1'b1;
    endtask

    // Monitor: output must match scoreboard head while valid; pop on transfer.
    always @(negedge clk) begin
        if (n_rst) begin
            chk("out_valid_vs_sb", {127'd0, out_valid}, {127'd0, sb.size() != 0});
            chk("in_ready", {127'd0, in_ready}, {127'd0, !zeroize && (!out_valid || out_ready)});
            chk("key_loaded", {117'd0, key_loaded}, {117'd0, mload});
            if (out_valid && sb.size() != 0) begin
                chk("beat_data", out_data, sb[0].data);
                chk("beat_err", {127'd0, out_err}, {127'd0, sb[0].err});
                if (out_ready) sb.delete(0);
            end
        end
    end

    initial begin
        logic a;
        int beats;
        int stall;
        clear_model();
        do_reset();

        for (int i = 0; i < NK; i++) cycle(1'b0, 4'd0, 128'd0, 1'b1, 1'b1, 4'(i), 128'(i), 1'b0, a);
        cycle(1'b0, 4'd0, 128'd0, 1'b1, 1'b1, 4'd13, 128'hDEAD, 1'b0, a);
        cycle(1'b1, 4'd3, {128{1'b1}}, 1'b1, 1'b0, 4'd0, 128'd0, 1'b0, a);
        idle(1'b0);
        chk("known_vec_data", out_data, {{124{1'b1}}, 4'hC});
        chk("known_vec_err", {127'd0, out_err}, 128'd0);

        cycle(1'b1, 4'd12, 128'h1234, 1'b1, 1'b0, 4'd0, 128'd0, 1'b0, a);
        idle(1'b0);
        chk("bad_round_data", out_data, 128'h1234);
        chk("bad_round_err", {127'd0, out_err}, 128'd1);
        cycle(1'b1, 4'd5, 128'h1234, 1'b1, 1'b0, 4'd0, 128'd0, 1'b0, a);
        idle(1'b0);
        chk("legal_after_bad_err", {127'd0, out_err}, 128'd0);

        cycle(1'b0, 4'd0, 128'd0, 1'b1, 1'b1, 4'd2, 128'h55, 1'b0, a);
        cycle(1'b1, 4'd2, 128'd0, 1'b0, 1'b1, 4'd2, 128'hAA, 1'b0, a);
        idle(1'b0);
        chk("wr_collide_old", out_data, 128'h55);
        cycle(1'b1, 4'd2, 128'd0, 1'b1, 1'b0, 4'd0, 128'd0, 1'b0, a);
        idle(1'b0);
        chk("wr_collide_new", out_data, 128'hAA);

        beats = 0; stall = 0;
        while (beats < 8) begin
            logic ordy;
            ordy = !(beats >= 1 && stall < 3);
            if (!ordy) stall++;
            cycle(1'b1, 4'(beats), 128'(beats * 32'h01010101), ordy, 1'b0, 4'd0, 128'd0, 1'b0, a);
            if (a) beats++;
        end
        idle(1'b1);

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom, $urandom, $urandom}, 1'b0, a);
        end
        idle(1'b1);

        cycle(1'b1, 4'd1, 128'h77, 1'b0, 1'b0, 4'd0, 128'd0, 1'b0, a);
        idle(1'b0);
        do_reset();
        cycle(1'b1, 4'd0, 128'h99, 1'b1, 1'b0, 4'd0, 128'd0, 1'b0, a);
        idle(1'b0);
        chk("post_reset_err", {127'd0, out_err}, 128'd1);
        chk("post_reset_data", out_data, 128'h99);

`ifdef KEY_ADD_ZEROIZE_EN
        cycle(1'b0, 4'd0, 128'd0, 1'b1, 1'b1, 4'd1, 128'h3C, 1'b0, a);
        cycle(1'b1, 4'd1, 128'h5, 1'b0, 1'b0, 4'd0, 128'd0, 1'b0, a);
        cycle(1'b1, 4'd1, 128'h6, 1'b0, 1'b1, 4'd0, 128'h11, 1'b1, a);
        chk("zeroize_in_ready", {127'd0, in_ready}, 128'd0);
        idle(1'b0);
        chk("zeroize_key_loaded", {117'd0, key_loaded}, 128'd0);
        chk("zeroize_out_valid", {127'd0, out_valid}, 128'd0);
`endif

        for (int n = 0; n < 20 && sb.size() != 0; n++) idle(1'b1);
        chk("drain_empty", 128'(sb.size()), 128'd0);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
